// File: rtl/fifo_read_logic.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_read_logic                                              |
// | Description : Read-side pointer/flag controller of the router's            |
// |               dual-pointer FIFO. Pops entries on consumer request, drives  |
// |               the RAM read address/strobe, returns a Gray read pointer to  |
// |               the write side and reports empty/occupancy.                  |
// | Options     : FIFO_RD_ALMOST_EMPTY_EN adds the registered ralmost_empty    |
// |               output (threshold AE_LEVEL).                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fifo_read_logic #(
  parameter int DEPTH    = 4,
  parameter int PTR_SZ   = 2,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rinc,
  input  logic [PTR_SZ:0]   rq2_wptr,
  output logic              rempty,
  output logic              read_en,
  output logic [PTR_SZ-1:0] raddr,
  output logic [PTR_SZ:0]   rptr_gray,
  output logic              rvalid,
  output logic [PTR_SZ:0]   rlevel
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  output logic              ralmost_empty
`endif
);

  // Two-state occupancy FSM; the encoding width is fixed at one bit.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_AVAIL = 1'b1
  } state_t;

  localparam logic [PTR_SZ:0] c_ONE = {{PTR_SZ{1'b0}}, 1'b1};

  // Reject configurations where DEPTH and PTR_SZ disagree or the
  // almost-empty threshold exceeds the FIFO size.
  if ((DEPTH != (1 << PTR_SZ)) || (DEPTH < 2) || (AE_LEVEL > DEPTH)) begin : g_bad_params
    $error("fifo_read_logic: inconsistent DEPTH/PTR_SZ/AE_LEVEL");
  end

  state_t            r_state;
  logic              r_rempty;
  logic [PTR_SZ:0]   r_rbin;
  logic [PTR_SZ:0]   r_rgray;
  logic              r_rvalid;
  logic [PTR_SZ:0]   r_rlevel;

  logic              w_pop;
  logic [PTR_SZ:0]   w_rbin_next;
  logic [PTR_SZ:0]   w_rgray_next;
  logic [PTR_SZ:0]   w_wbin;
  logic              w_empty_next;
  logic [PTR_SZ:0]   w_level_next;

  // A pop is only honoured while the FIFO is known to hold data.
  assign w_pop        = rinc & ~r_rempty;
  assign w_rbin_next  = w_pop ? (r_rbin + c_ONE) : r_rbin;
  assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

  // Convert the synchronized Gray write pointer back to binary so the
  // occupancy can be computed as a plain modulo difference.
  for (genvar i = 0; i <= PTR_SZ; i++) begin : g_gray2bin
    assign w_wbin[i] = ^(rq2_wptr >> i);
  end

  // Compare in the Gray domain so the freshly sampled write pointer is used
  // directly; a pop and a write in the same cycle keep the FIFO non-empty.
  assign w_empty_next = (w_rgray_next == rq2_wptr);
  assign w_level_next = w_wbin - w_rbin_next;

  // Occupancy FSM with its registered empty flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_rempty <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (!w_empty_next) begin
            r_state  <= ST_AVAIL;
            r_rempty <= 1'b0;
          end
        end
        ST_AVAIL: begin
          if (w_empty_next) begin
            r_state  <= ST_EMPTY;
            r_rempty <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_EMPTY;
          r_rempty <= 1'b1;
        end
      endcase
    end
  end

  // Read pointer (binary and Gray), read-data valid and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rbin   <= '0;
      r_rgray  <= '0;
      r_rvalid <= 1'b0;
      r_rlevel <= '0;
    end else begin
      r_rbin   <= w_rbin_next;
      r_rgray  <= w_rgray_next;
      r_rvalid <= w_pop;
      r_rlevel <= w_level_next;
    end
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  localparam logic [PTR_SZ:0] c_AE_LEVEL = AE_LEVEL[PTR_SZ:0];

  logic r_ralmost_empty;

  // Almost-empty flag, updated on the same edge as the empty flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ralmost_empty <= 1'b1;
    end else begin
      r_ralmost_empty <= (w_level_next <= c_AE_LEVEL);
    end
  end

  assign ralmost_empty = r_ralmost_empty;
`endif

  // The RAM samples raddr on the same edge that read_en is high.
  assign rempty    = r_rempty;
  assign read_en   = w_pop;
  assign raddr     = r_rbin[PTR_SZ-1:0];
  assign rptr_gray = r_rgray;
  assign rvalid    = r_rvalid;
  assign rlevel    = r_rlevel;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_logic.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fifo_read_logic                                           |
// | Description : Self-checking bench for fifo_read_logic (DEPTH=4). A         |
// |               count-based occupancy model is compared every cycle, plus    |
// |               hand-computed directed expectations.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fifo_read_logic;

  logic       clk;
  logic       rst;
  logic       rinc;
  logic [2:0] rq2_wptr;
  logic       rempty;
  logic       read_en;
  logic [1:0] raddr;
  logic [2:0] rptr_gray;
  logic       rvalid;
  logic [2:0] rlevel;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic       ralmost_empty;
`endif

  int tests = 0;
  int fails = 0;

  // Bench-side write count (entries ever written, mod 8).
  logic [2:0] wcnt;

  fifo_read_logic #(
    .DEPTH    (4),
    .PTR_SZ   (2),
    .AE_LEVEL (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .rempty        (rempty),
    .read_en       (read_en),
    .raddr         (raddr),
    .rptr_gray     (rptr_gray),
    .rvalid        (rvalid),
    .rlevel        (rlevel)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    .ralmost_empty (ralmost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model: counts of entries written and read ----------------
  logic [2:0] m_rd;
  logic       m_empty;
  logic       m_valid;
  logic [2:0] m_level;
  logic       m_ae;

  wire        m_pop    = rinc & ~m_empty;
  wire  [2:0] m_rd_nx  = m_rd + {2'b00, m_pop};
  wire  [2:0] m_lvl_nx = wcnt - m_rd_nx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rd    <= 3'd0;
      m_empty <= 1'b1;
      m_valid <= 1'b0;
      m_level <= 3'd0;
      m_ae    <= 1'b1;
    end else begin
      m_rd    <= m_rd_nx;
      m_empty <= (m_lvl_nx == 3'd0);
      m_valid <= m_pop;
      m_level <= m_lvl_nx;
      m_ae    <= (m_lvl_nx <= 3'd1);
    end
  end

  function automatic logic [2:0] to_gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    check("cyc rempty",    {31'd0, rempty},    {31'd0, m_empty});
    check("cyc read_en",   {31'd0, read_en},   {31'd0, m_pop});
    check("cyc raddr",     {30'd0, raddr},     {30'd0, m_rd[1:0]});
    check("cyc rptr_gray", {29'd0, rptr_gray}, {29'd0, to_gray(m_rd)});
    check("cyc rvalid",    {31'd0, rvalid},    {31'd0, m_valid});
    check("cyc rlevel",    {29'd0, rlevel},    {29'd0, m_level});
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    check("cyc ralmost_empty", {31'd0, ralmost_empty}, {31'd0, m_ae});
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic inc, input int wadv);
    rinc     = inc;
    wcnt     = wcnt + wadv[2:0];
    rq2_wptr = to_gray(wcnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_checks();
    check("rst rempty",    {31'd0, rempty},  32'd1);
    check("rst raddr",     {30'd0, raddr},   32'd0);
    check("rst rptr_gray", {29'd0, rptr_gray}, 32'd0);
    check("rst read_en",   {31'd0, read_en}, 32'd0);
    check("rst rvalid",    {31'd0, rvalid},  32'd0);
    check("rst rlevel",    {29'd0, rlevel},  32'd0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    check("rst ralmost_empty", {31'd0, ralmost_empty}, 32'd1);
`endif
  endtask

  // Asynchronous reset applied between edges; the whole FIFO restarts at 0.
  task automatic do_reset();
    rst      = 1'b1;
    wcnt     = 3'd0;
    rq2_wptr = 3'd0;
    #1;
    reset_checks();
    tick();
    rst = 1'b0;
  endtask

  logic [2:0] gray_tbl [8];

  initial begin
    gray_tbl[0] = 3'b001; gray_tbl[1] = 3'b011; gray_tbl[2] = 3'b010; gray_tbl[3] = 3'b110;
    gray_tbl[4] = 3'b111; gray_tbl[5] = 3'b101; gray_tbl[6] = 3'b100; gray_tbl[7] = 3'b000;

    rst      = 1'b0;
    rinc     = 1'b0;
    wcnt     = 3'd0;
    rq2_wptr = 3'd0;
    #1;
    do_reset();

    // Three entries become visible; pop them one by one.
    set_in(1'b0, 3);
    tick();
    check("t2 rempty", {31'd0, rempty}, 32'd0);
    check("t2 rlevel", {29'd0, rlevel}, 32'd3);
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 0);
      #1;
      check("t2 read_en", {31'd0, read_en}, 32'd1);
      check("t2 raddr",   {30'd0, raddr},   k);
      tick();
      check("t2 rvalid",  {31'd0, rvalid},  32'd1);
    end
    set_in(1'b0, 0);
    tick();
    check("t2 rempty after", {31'd0, rempty},    32'd1);
    check("t2 rlevel after", {29'd0, rlevel},    32'd0);
    check("t2 gray after",   {29'd0, rptr_gray}, 32'b010);
    check("t2 rvalid after", {31'd0, rvalid},    32'd0);

    // Pop requests on an empty FIFO are ignored.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 0);
      #1;
      check("t3 read_en", {31'd0, read_en}, 32'd0);
      tick();
      check("t3 raddr",   {30'd0, raddr},     32'd0);
      check("t3 gray",    {29'd0, rptr_gray}, 32'd0);
      check("t3 rvalid",  {31'd0, rvalid},    32'd0);
    end

    // Interleaved single writes and pops across a full wrap.
    for (int k = 0; k < 8; k++) begin
      set_in(1'b0, 1);
      tick();
      set_in(1'b1, 0);
      #1;
      check("t4 raddr", {30'd0, raddr}, k % 4);
      tick();
      check("t4 gray",  {29'd0, rptr_gray}, {29'd0, gray_tbl[k]});
    end
    set_in(1'b0, 0);
    tick();

    // Full FIFO: four entries outstanding, then drained.
    set_in(1'b0, 4);
    check("t5 wptr", {29'd0, rq2_wptr}, 32'b110);
    tick();
    check("t5 rlevel", {29'd0, rlevel}, 32'd4);
    check("t5 rempty", {31'd0, rempty}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 0);
      tick();
    end
    set_in(1'b0, 0);
    check("t5 rempty after", {31'd0, rempty},    32'd1);
    check("t5 gray after",   {29'd0, rptr_gray}, 32'b110);
    tick();

    // Almost-empty tracking, simultaneous pop/write, then reset mid-pop.
    set_in(1'b0, 3);
    tick();
    check("t6 rlevel 3", {29'd0, rlevel}, 32'd3);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    check("t6 ae at 3", {31'd0, ralmost_empty}, 32'd0);
`endif
    set_in(1'b1, 0);
    tick();
    tick();
    check("t6 rlevel 1", {29'd0, rlevel}, 32'd1);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    check("t6 ae at 1", {31'd0, ralmost_empty}, 32'd1);
`endif
    set_in(1'b1, 1);
    tick();
    check("t6 pop+write rempty", {31'd0, rempty}, 32'd0);
    check("t6 pop+write rlevel", {29'd0, rlevel}, 32'd1);
    set_in(1'b1, 0);
    #1;
    check("t6 read_en pre-rst", {31'd0, read_en}, 32'd1);
    do_reset();
    check("t6 rvalid post-rst", {31'd0, rvalid}, 32'd0);
    tick();
    check("t6 rvalid later",    {31'd0, rvalid}, 32'd0);
    check("t6 rempty later",    {31'd0, rempty}, 32'd1);
    set_in(1'b0, 0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
